// File: rtl/periph_bus_slave_adapter.sv
// periph_bus_slave_adapter
// Slave-side endpoint of the peripheral crossbar. Requests from one crossbar
// slave port are buffered in a small in-order FIFO and issued to a simple
// peripheral register port. The id of every issued access is queued until the
// peripheral answers, and each answer is registered and returned with that id.
// Optional feature macro: PERIPH_ADAPTER_ERR_EN (return per_r_err_i on slv_r_opc_o).
module periph_bus_slave_adapter #(
  parameter int unsigned ID_WIDTH        = 9,
  parameter int unsigned REQ_DEPTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // crossbar request channel
  input  logic                slv_req_i,
  input  logic [31:0]         slv_add_i,
  input  logic                slv_wen_i,
  input  logic [31:0]         slv_wdata_i,
  input  logic [3:0]          slv_be_i,
  input  logic [ID_WIDTH-1:0] slv_id_i,
  output logic                slv_gnt_o,
  // crossbar response channel
  output logic                slv_r_valid_o,
  output logic                slv_r_opc_o,
  output logic [ID_WIDTH-1:0] slv_r_id_o,
  output logic [31:0]         slv_r_rdata_o,
  // peripheral register port
  output logic                per_req_o,
  output logic [31:0]         per_add_o,
  output logic                per_wen_o,
  output logic [31:0]         per_wdata_o,
  output logic [3:0]          per_be_o,
  input  logic                per_gnt_i,
  input  logic                per_r_valid_i,
  input  logic [31:0]         per_r_rdata_i,
  input  logic                per_r_err_i
);

  localparam int unsigned REQ_PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned REQ_CNT_W = $clog2(REQ_DEPTH) + 1;
  localparam int unsigned ID_PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OUT_CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic [31:0]         add;
    logic                wen;
    logic [31:0]         wdata;
    logic [3:0]          be;
    logic [ID_WIDTH-1:0] id;
  } req_t;

  // request FIFO
  req_t                 req_mem [REQ_DEPTH];
  logic [REQ_PTR_W-1:0] req_wr_ptr, req_rd_ptr;
  logic [REQ_CNT_W-1:0] req_cnt;
  logic                 req_full, req_empty;
  req_t                 req_head;

  // id FIFO, one entry per issued-but-unanswered access
  logic [ID_WIDTH-1:0]  id_mem [MAX_OUTSTANDING];
  logic [ID_PTR_W-1:0]  id_wr_ptr, id_rd_ptr;
  logic [OUT_CNT_W-1:0] outstanding;

  logic push, issue, rsp_ok;

  // Pointer advance that also covers a single-entry id FIFO.
  function automatic logic [ID_PTR_W-1:0] id_ptr_inc(input logic [ID_PTR_W-1:0] p);
    return (p == ID_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + ID_PTR_W'(1);
  endfunction

  // Handshake decode. A full FIFO never grants, even while it pops.
  assign req_full  = (req_cnt == REQ_CNT_W'(REQ_DEPTH));
  assign req_empty = (req_cnt == '0);
  assign slv_gnt_o = slv_req_i & ~req_full;
  assign push      = slv_req_i & slv_gnt_o;
  assign per_req_o = ~req_empty & (outstanding < OUT_CNT_W'(MAX_OUTSTANDING));
  assign issue     = per_req_o & per_gnt_i;
  // A response with nothing outstanding (e.g. in flight across a reset) is dropped.
  assign rsp_ok    = per_r_valid_i & (outstanding != '0);

  // Head fields are forced to zero while empty so the port is clean after reset.
  assign req_head    = req_empty ? '0 : req_mem[req_rd_ptr];
  assign per_add_o   = req_head.add;
  assign per_wen_o   = req_head.wen;
  assign per_wdata_o = req_head.wdata;
  assign per_be_o    = req_head.be;

  // Request FIFO storage write.
  // NOTE: storage arrays carry no reset; only pointers/counters do, and the
  // empty flag masks whatever stale data the array holds.
  always_ff @(posedge clk_i) begin
    if (push) begin
      req_mem[req_wr_ptr] <= '{add: slv_add_i, wen: slv_wen_i, wdata: slv_wdata_i,
                               be: slv_be_i, id: slv_id_i};
    end
  end

  // Request FIFO pointers and occupancy.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_cnt    <= '0;
    end else begin
      if (push)  req_wr_ptr <= req_wr_ptr + REQ_PTR_W'(1);
      if (issue) req_rd_ptr <= req_rd_ptr + REQ_PTR_W'(1);
      case ({push, issue})
        2'b10:   req_cnt <= req_cnt + REQ_CNT_W'(1);
        2'b01:   req_cnt <= req_cnt - REQ_CNT_W'(1);
        default: req_cnt <= req_cnt;
      endcase
    end
  end

  // Id FIFO storage: the head id of every issued access.
  always_ff @(posedge clk_i) begin
    if (issue) id_mem[id_wr_ptr] <= req_head.id;
  end

  // Id FIFO pointers and the outstanding-access counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_wr_ptr   <= '0;
      id_rd_ptr   <= '0;
      outstanding <= '0;
    end else begin
      if (issue)  id_wr_ptr <= id_ptr_inc(id_wr_ptr);
      if (rsp_ok) id_rd_ptr <= id_ptr_inc(id_rd_ptr);
      case ({issue, rsp_ok})
        2'b10:   outstanding <= outstanding + OUT_CNT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Response register: one-cycle valid pulse, payload holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slv_r_valid_o <= 1'b0;
      slv_r_id_o    <= '0;
      slv_r_rdata_o <= '0;
    end else begin
      slv_r_valid_o <= rsp_ok;
      if (rsp_ok) begin
        slv_r_id_o    <= id_mem[id_rd_ptr];
        slv_r_rdata_o <= per_r_rdata_i;
      end
    end
  end

`ifdef PERIPH_ADAPTER_ERR_EN
  // Error flag travels with the response payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slv_r_opc_o <= 1'b0;
    end else if (rsp_ok) begin
      slv_r_opc_o <= per_r_err_i;
    end
  end
`else
  logic unused_err;
  assign unused_err  = per_r_err_i;
  assign slv_r_opc_o = 1'b0;
`endif

  // Flag a peripheral response that arrives with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_ni && per_r_valid_i) begin
      spurious_rsp_chk: assert (outstanding != '0)
        else $warning("periph_bus_slave_adapter: response with no outstanding access dropped");
    end
  end

endmodule

// File: tb/tb_periph_bus_slave_adapter.sv
// tb_periph_bus_slave_adapter
// Directed stimulus with a queue-based reference model checked on every
// falling edge, plus literal expectations at key points of each scenario.
module tb_periph_bus_slave_adapter;

  localparam int unsigned ID_W  = 9;
  localparam int unsigned RDEP  = 2;
  localparam int unsigned MAXO  = 4;
`ifdef PERIPH_ADAPTER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            slv_req;
  logic [31:0]     slv_add;
  logic            slv_wen;
  logic [31:0]     slv_wdata;
  logic [3:0]      slv_be;
  logic [ID_W-1:0] slv_id;
  logic            slv_gnt_o;
  logic            slv_r_valid_o;
  logic            slv_r_opc_o;
  logic [ID_W-1:0] slv_r_id_o;
  logic [31:0]     slv_r_rdata_o;
  logic            per_req_o;
  logic [31:0]     per_add_o;
  logic            per_wen_o;
  logic [31:0]     per_wdata_o;
  logic [3:0]      per_be_o;
  logic            per_gnt;
  logic            per_r_valid;
  logic [31:0]     per_r_rdata;
  logic            per_r_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  periph_bus_slave_adapter #(
    .ID_WIDTH(ID_W), .REQ_DEPTH(RDEP), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_req), .slv_add_i(slv_add), .slv_wen_i(slv_wen),
    .slv_wdata_i(slv_wdata), .slv_be_i(slv_be), .slv_id_i(slv_id),
    .slv_gnt_o(slv_gnt_o),
    .slv_r_valid_o(slv_r_valid_o), .slv_r_opc_o(slv_r_opc_o),
    .slv_r_id_o(slv_r_id_o), .slv_r_rdata_o(slv_r_rdata_o),
    .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
    .per_wdata_o(per_wdata_o), .per_be_o(per_be_o), .per_gnt_i(per_gnt),
    .per_r_valid_i(per_r_valid), .per_r_rdata_i(per_r_rdata), .per_r_err_i(per_r_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0]     add;
    logic            wen;
    logic [31:0]     wdata;
    logic [3:0]      be;
    logic [ID_W-1:0] id;
  } req_t;

  req_t            req_q[$];
  logic [ID_W-1:0] id_q[$];
  logic            m_r_valid, m_r_opc;
  logic [ID_W-1:0] m_r_id;
  logic [31:0]     m_r_rdata;

  // Transaction-level update: accept, issue and answer using queue occupancy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q.delete();
      id_q.delete();
      m_r_valid = 1'b0;
      m_r_opc   = 1'b0;
      m_r_id    = '0;
      m_r_rdata = '0;
    end else begin
      bit   acc, iss, rsp;
      req_t nreq;
      acc = slv_req && (req_q.size() < RDEP);
      iss = per_gnt && (req_q.size() > 0) && (id_q.size() < MAXO);
      rsp = per_r_valid && (id_q.size() > 0);
      m_r_valid = rsp;
      if (rsp) begin
        m_r_id    = id_q[0];
        m_r_rdata = per_r_rdata;
        m_r_opc   = ERR_EN & per_r_err;
        void'(id_q.pop_front());
      end
      if (iss) begin
        id_q.push_back(req_q[0].id);
        void'(req_q.pop_front());
      end
      if (acc) begin
        nreq = '{add: slv_add, wen: slv_wen, wdata: slv_wdata, be: slv_be, id: slv_id};
        req_q.push_back(nreq);
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    req_t h;
    h = (req_q.size() > 0) ? req_q[0] : '0;
    check("m_gnt",     32'(slv_gnt_o),     32'(slv_req && (req_q.size() < RDEP)));
    check("m_per_req", 32'(per_req_o),     32'((req_q.size() > 0) && (id_q.size() < MAXO)));
    check("m_per_add", per_add_o,          h.add);
    check("m_per_wen", 32'(per_wen_o),     32'(h.wen));
    check("m_per_wd",  per_wdata_o,        h.wdata);
    check("m_per_be",  32'(per_be_o),      32'(h.be));
    check("m_r_valid", 32'(slv_r_valid_o), 32'(m_r_valid));
    check("m_r_id",    32'(slv_r_id_o),    32'(m_r_id));
    check("m_r_rdata", slv_r_rdata_o,      m_r_rdata);
    check("m_r_opc",   32'(slv_r_opc_o),   32'(m_r_opc));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slv_req = 1'b0; per_gnt = 1'b0; per_r_valid = 1'b0; per_r_err = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] be, input logic [ID_W-1:0] id);
    slv_req = 1'b1; slv_add = a; slv_wen = w; slv_wdata = d; slv_be = be; slv_id = id;
  endtask

  // Answer and issue everything the model holds, bounded.
  task automatic drain();
    int n;
    n = 0;
    while ((req_q.size() > 0 || id_q.size() > 0) && n < 40) begin
      slv_req     = 1'b0;
      per_gnt     = 1'b1;
      per_r_valid = (id_q.size() > 0);
      per_r_rdata = $urandom;
      step();
      n++;
    end
    check("drain_done", 32'(req_q.size() + id_q.size()), 32'd0);
    idle_inputs();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, issues;
    rst_n = 1'b0;
    idle_inputs();
    slv_add = '0; slv_wen = 1'b0; slv_wdata = '0; slv_be = '0; slv_id = '0;
    per_r_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_gnt",     32'(slv_gnt_o),     32'd0);
    check("rst_per_req", 32'(per_req_o),     32'd0);
    check("rst_r_valid", 32'(slv_r_valid_o), 32'd0);
    check("rst_per_add", per_add_o,          32'd0);
    step();

    // single read, zero-wait peripheral
    drive_req(32'h1A10_0004, 1'b1, 32'h0, 4'hF, 9'h005);
    @(negedge clk); check("t1_gnt", 32'(slv_gnt_o), 32'd1);
    step(); slv_req = 1'b0; per_gnt = 1'b1;
    @(negedge clk);
    check("t1_per_req", 32'(per_req_o), 32'd1);
    check("t1_per_add", per_add_o, 32'h1A10_0004);
    step(); per_gnt = 1'b0; per_r_valid = 1'b1; per_r_rdata = 32'hDEAD_BEEF;
    @(negedge clk); check("t1_no_early_valid", 32'(slv_r_valid_o), 32'd0);
    step(); per_r_valid = 1'b0;
    @(negedge clk);
    check("t1_r_valid", 32'(slv_r_valid_o), 32'd1);
    check("t1_r_id",    32'(slv_r_id_o),    32'h005);
    check("t1_r_rdata", slv_r_rdata_o,      32'hDEAD_BEEF);
    step();
    @(negedge clk); check("t1_valid_pulse", 32'(slv_r_valid_o), 32'd0);
    step();

    // three back-to-back writes against a stalled peripheral
    drive_req(32'h100, 1'b0, 32'h1111_1111, 4'h1, 9'd1);
    @(negedge clk); check("t2_gnt0", 32'(slv_gnt_o), 32'd1);
    step(); drive_req(32'h104, 1'b0, 32'h2222_2222, 4'h3, 9'd2);
    @(negedge clk); check("t2_gnt1", 32'(slv_gnt_o), 32'd1);
    step(); drive_req(32'h108, 1'b0, 32'h3333_3333, 4'hC, 9'd3);
    @(negedge clk); check("t2_gnt2_full", 32'(slv_gnt_o), 32'd0);
    step(); per_gnt = 1'b1;
    @(negedge clk);
    check("t2_full_pop_nogrant", 32'(slv_gnt_o), 32'd0);
    check("t2_head1", per_wdata_o, 32'h1111_1111);
    step();
    @(negedge clk);
    check("t2_gnt3", 32'(slv_gnt_o), 32'd1);
    check("t2_head2", per_wdata_o, 32'h2222_2222);
    step(); slv_req = 1'b0;
    @(negedge clk); check("t2_head3", per_wdata_o, 32'h3333_3333);
    step(); per_gnt = 1'b0; per_r_valid = 1'b1; per_r_rdata = 32'h0000_00A1;
    step(); per_r_rdata = 32'h0000_00A2;
    @(negedge clk); check("t2_rid1", 32'(slv_r_id_o), 32'd1);
    step(); per_r_rdata = 32'h0000_00A3;
    @(negedge clk);
    check("t2_rid2", 32'(slv_r_id_o), 32'd2);
    check("t2_wr_rdata", slv_r_rdata_o, 32'h0000_00A2);
    step(); per_r_valid = 1'b0;
    @(negedge clk); check("t2_rid3", 32'(slv_r_id_o), 32'd3);
    step();

    // outstanding limit: peripheral grants, never answers
    cur = 'h40; issues = 0; per_gnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_req(32'h200 + 32'(cur), 1'b1, 32'h0, 4'hF, ID_W'(cur));
      @(negedge clk);
      if (per_req_o && per_gnt) issues++;
      if (slv_gnt_o) cur++;
      step();
    end
    check("t3_issues_limit", 32'(issues), 32'd4);
    slv_req = 1'b0; per_r_valid = 1'b1; per_r_rdata = 32'h0000_0C01; issues = 0;
    @(negedge clk); check("t3_blocked", 32'(per_req_o), 32'd0);
    if (per_req_o && per_gnt) issues++;
    step(); per_r_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (per_req_o && per_gnt) issues++;
      step();
    end
    check("t3_one_reissue", 32'(issues), 32'd1);
    drain();

    // issue and response in the same cycle at outstanding == 2
    drive_req(32'h300, 1'b1, 32'h0, 4'hF, 9'h010);
    step(); drive_req(32'h304, 1'b1, 32'h0, 4'hF, 9'h011); per_gnt = 1'b1;
    step(); drive_req(32'h308, 1'b1, 32'h0, 4'hF, 9'h012);
    step(); slv_req = 1'b0; per_r_valid = 1'b1; per_r_rdata = 32'h0000_0D10;
    @(negedge clk); check("t4_pre_out", 32'(dut.outstanding), 32'd2);
    step(); per_gnt = 1'b0; per_r_rdata = 32'h0000_0D11;
    @(negedge clk);
    check("t4_out_same", 32'(dut.outstanding), 32'd2);
    check("t4_rid0", 32'(slv_r_id_o), 32'h010);
    step(); per_r_rdata = 32'h0000_0D12;
    @(negedge clk); check("t4_rid1", 32'(slv_r_id_o), 32'h011);
    step(); per_r_valid = 1'b0;
    @(negedge clk);
    check("t4_rid2", 32'(slv_r_id_o), 32'h012);
    check("t4_out_zero", 32'(dut.outstanding), 32'd0);
    step();

    // error flag
    drive_req(32'h400, 1'b1, 32'h0, 4'hF, 9'h007);
    step(); slv_req = 1'b0; per_gnt = 1'b1;
    step(); per_gnt = 1'b0; per_r_valid = 1'b1; per_r_err = 1'b1; per_r_rdata = 32'h0BAD_0BAD;
    step(); per_r_valid = 1'b0; per_r_err = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(slv_r_valid_o), 32'd1);
    check("t5_opc",   32'(slv_r_opc_o),   32'(ERR_EN));
    step();

    // reset with 2 queued and 2 outstanding
    drive_req(32'h500, 1'b1, 32'h5, 4'hF, 9'h020);
    step(); drive_req(32'h504, 1'b1, 32'h6, 4'hF, 9'h021); per_gnt = 1'b1;
    step(); drive_req(32'h508, 1'b1, 32'h7, 4'hF, 9'h022);
    step(); drive_req(32'h50C, 1'b1, 32'h8, 4'hF, 9'h023); per_gnt = 1'b0;
    step(); slv_req = 1'b0;
    @(negedge clk);
    check("t6_pre_out", 32'(dut.outstanding), 32'd2);
    check("t6_pre_req", 32'(per_req_o), 32'd1);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("t6_gnt",     32'(slv_gnt_o),     32'd0);
    check("t6_per_req", 32'(per_req_o),     32'd0);
    check("t6_per_add", per_add_o,          32'd0);
    check("t6_per_wd",  per_wdata_o,        32'd0);
    check("t6_per_be",  32'(per_be_o),      32'd0);
    check("t6_per_wen", 32'(per_wen_o),     32'd0);
    check("t6_r_valid", 32'(slv_r_valid_o), 32'd0);
    check("t6_r_id",    32'(slv_r_id_o),    32'd0);
    check("t6_r_rdata", slv_r_rdata_o,      32'd0);
    check("t6_r_opc",   32'(slv_r_opc_o),   32'd0);
    #1 rst_n = 1'b1;
    step(); per_r_valid = 1'b1; per_r_rdata = 32'h0000_0055;
    step(); per_r_valid = 1'b0;
    @(negedge clk);
    check("t6_spurious_dropped", 32'(slv_r_valid_o), 32'd0);
    check("t6_spurious_rdata",   slv_r_rdata_o,      32'd0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
